clap_detector: RTL
==================

CLAP_DETECTOR -- requirements
Module: clap_detector

Interface
REQ-001 Parameter WINDOW, default 256: samples per detection window, range 2..65535.
REQ-002 Parameter THRESHOLD, default 32'd50000000: magnitude a window peak must strictly exceed.
REQ-003 Parameter HOLDOFF, default 48: windows ignored after a detected clap, range 1..255.
REQ-004 clk  in  1  system clock (CLOCK_50 at top level).
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 enable  in  1  detection armed (game in Game/Mole states).
REQ-007 audio_in_available  in  1  Audio_Controller ADC FIFO holds a sample.
REQ-008 left_channel_audio_in  in  32  signed left sample, valid while audio_in_available is high.
REQ-009 right_channel_audio_in  in  32  signed right sample, valid while audio_in_available is high.
REQ-010 read_audio_in  out  1  one-cycle pop strobe to the Audio_Controller ADC FIFO.
REQ-011 clap_pulse  out  1  one-cycle pulse, clap detected.
REQ-012 peak_level  out  8  peak magnitude bits [30:23] of the last completed window.
REQ-013 holdoff_active  out  1  high while clap detection is suppressed.

Function
REQ-014 This block is the reader of the ADC FIFO. read_audio_in is registered and is asserted only in a cycle where audio_in_available is high and read_audio_in was low in the previous cycle, so there are at most one pop per two cycles.
REQ-015 The sample pair is captured in the cycle read_audio_in is high; one pop consumes exactly one sample.
REQ-016 Popping continues in every state, including when enable is low, so the FIFO never overflows; samples read while enable is low are discarded.
REQ-017 Magnitude is |x| of the signed 32-bit sample; -2^31 saturates to 2^31-1. Sample magnitude is max(|L|,|R|) and is 31 bits unsigned.
REQ-018 Window peak register: on each captured sample, peak <= max(peak, magnitude). The sample counter increments once per captured sample.
REQ-019 Window close occurs on the capture of sample number WINDOW. In the same cycle: peak_level <= peak_final[30:23], the counter and peak clear, and peak_final includes the closing sample.
REQ-020 States: IDLE, LISTEN, HOLDOFF.
REQ-021 IDLE: when enable is high, go to LISTEN with the counter and peak cleared, so the next window starts fresh.
REQ-022 LISTEN: at window close, if peak_final > THRESHOLD, assert clap_pulse in the next cycle, load the holdoff count with HOLDOFF, and go to HOLDOFF. Otherwise stay in LISTEN.
REQ-023 HOLDOFF: decrement the count at each window close and return to LISTEN when it reaches 0. peak_level keeps updating during HOLDOFF. holdoff_active = (state==HOLDOFF).
REQ-024 When enable goes low in any state, go to IDLE in the next cycle, clear the counter, peak and holdoff count, and suppress any clap_pulse not yet emitted. peak_level holds its value.
REQ-025 clap_pulse is never high for two consecutive cycles; at most one clap is reported per HOLDOFF+1 windows.
REQ-026 A sample equal to THRESHOLD does not trigger a clap (the comparison is strict).

Reset
REQ-027 While reset is high: state=IDLE; read_audio_in=0, clap_pulse=0, holdoff_active=0, peak_level=0; counter, peak and holdoff count = 0.
REQ-028 Reset mid-window discards the partial window; no pop is issued in the reset cycle.
REQ-029 Reset has priority over enable and audio_in_available.

Verification
REQ-030 Pop handshake: WINDOW=4, audio_in_available held high for 20 cycles -> read_audio_in toggles 1,0,1,0…, 10 pops total, never two consecutive highs.
REQ-031 Detection: WINDOW=4, THRESHOLD=1000, enable=1, samples L={10,-2000,5,5}, R=0 -> clap_pulse one cycle after the 4th pop, peak_level=2000>>23=0, holdoff_active=1.
REQ-032 Threshold edge and saturation: sample magnitude exactly 1000 -> no pulse. L=32'h80000000 -> peak_level=8'hFF and a pulse occurs.
REQ-033 Holdoff: HOLDOFF=2, loud samples every window -> pulses at windows 1, 4, 7; holdoff_active high across windows 2–3 and 5–6.
REQ-034 Enable drop: enable falls mid-window containing a loud sample -> no clap_pulse, state IDLE, pops continue. After enable re-rises, the first pulse comes only after a full new WINDOW.
REQ-035 Reset mid-operation: reset asserted during HOLDOFF -> next cycle all outputs 0, state IDLE, and no read_audio_in while reset is high.

Source files
------------

// File: rtl/clap_detector.sv
// Clap detector: pops stereo samples from the ADC FIFO, tracks the peak magnitude per window,
// pulses when a window peak strictly exceeds THRESHOLD, then ignores HOLDOFF windows.
module clap_detector #(
    parameter int          WINDOW    = 256,
    parameter logic [31:0] THRESHOLD = 32'd50000000,
    parameter int          HOLDOFF   = 48
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        audio_in_available,
    input  logic [31:0] left_channel_audio_in,
    input  logic [31:0] right_channel_audio_in,
    output logic        read_audio_in,
    output logic        clap_pulse,
    output logic [7:0]  peak_level,
    output logic        holdoff_active
);
    typedef enum logic [1:0] {ST_IDLE, ST_LISTEN, ST_HOLDOFF} state_t;

    state_t      state_reg, state_next;
    logic        read_reg, read_next;
    logic        clap_reg, clap_next;
    logic [15:0] count_reg, count_next;
    logic [30:0] peak_reg, peak_next;
    logic [7:0]  hold_reg, hold_next;
    logic [7:0]  level_reg, level_next;

    logic [31:0] chan [2];
    logic [30:0] chan_mag [2];
    logic [30:0] sample_mag;
    logic [30:0] peak_final;
    logic        capture;
    logic        window_close;

    assign chan[0] = left_channel_audio_in;
    assign chan[1] = right_channel_audio_in;

    // |x| per channel; the most negative value saturates instead of wrapping to itself
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mag
            logic [31:0] neg;
            assign neg = 32'd0 - chan[gi];
            assign chan_mag[gi] = (chan[gi] == 32'h8000_0000) ? 31'h7FFF_FFFF :
                                  chan[gi][31]                ? neg[30:0]     :
                                                                chan[gi][30:0];
        end
    endgenerate

    assign sample_mag   = (chan_mag[0] > chan_mag[1]) ? chan_mag[0] : chan_mag[1];
    assign peak_final   = (sample_mag > peak_reg) ? sample_mag : peak_reg;
    assign capture      = read_reg;
    assign window_close = capture && (count_reg == 16'(WINDOW - 1));

    always_comb begin
        state_next = state_reg;
        read_next  = audio_in_available && !read_reg;
        clap_next  = 1'b0;
        count_next = count_reg;
        peak_next  = peak_reg;
        hold_next  = hold_reg;
        level_next = level_reg;
        if (!enable) begin
            state_next = ST_IDLE;
            count_next = '0;
            peak_next  = '0;
            hold_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_LISTEN;
                    count_next = '0;
                    peak_next  = '0;
                end
                ST_LISTEN, ST_HOLDOFF: begin
                    if (window_close) begin
                        count_next = '0;
                        peak_next  = '0;
                        level_next = peak_final[30:23];
                        if (state_reg == ST_LISTEN) begin
                            if ({1'b0, peak_final} > THRESHOLD) begin
                                clap_next  = 1'b1;
                                hold_next  = 8'(HOLDOFF);
                                state_next = ST_HOLDOFF;
                            end
                        end else begin
                            hold_next = hold_reg - 8'd1;
                            if (hold_reg == 8'd1)
                                state_next = ST_LISTEN;
                        end
                    end else if (capture) begin
                        count_next = count_reg + 16'd1;
                        peak_next  = peak_final;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            read_reg  <= 1'b0;
            clap_reg  <= 1'b0;
            count_reg <= '0;
            peak_reg  <= '0;
            hold_reg  <= '0;
            level_reg <= '0;
        end else begin
            state_reg <= state_next;
            read_reg  <= read_next;
            clap_reg  <= clap_next;
            count_reg <= count_next;
            peak_reg  <= peak_next;
            hold_reg  <= hold_next;
            level_reg <= level_next;
        end
    end

    // The strobe is masked while reset is high so the FIFO is never popped in a reset cycle
    assign read_audio_in  = read_reg & ~reset;
    assign clap_pulse     = clap_reg;
    assign peak_level     = level_reg;
    assign holdoff_active = (state_reg == ST_HOLDOFF);

endmodule
